// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver for the signal logger front end.
// Deserialises frames with DATA_BITS data bits, optional parity and one or
// two stop bits. Good words go out on a valid/ready register. Framing,
// parity, overrun and break conditions are reported as one-cycle pulses.
//
// Optional feature macro: RX_MAJORITY_VOTE_EN
//   When defined, each bit decision is the 2-of-3 vote of rx_s at mid-1,
//   mid and mid+1. The decision is taken at mid+1, so every sample, and
//   therefore completion, lands one cycle later.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s low
// START     | timing to mid start bit, then confirm or reject the start
// DATA      | sampling DATA_BITS data bits, LSB first, DIV cycles apart
// PARITY    | sampling the parity bit (only when PARITY_MODE != 0)
// STOP      | sampling STOP_BITS stop bits; last sample triggers completion
// WAIT_IDLE | after a framing error, waiting for the line to return high
module uart_rx_param #(
    parameter int          CLK_FREQ_HZ = 100_000_000,
    parameter int          BAUD_RATE   = 115_200,
    parameter int          DATA_BITS   = 8,
    parameter int          PARITY_MODE = 0,
    parameter int          STOP_BITS   = 1,
    parameter int unsigned RESET_VALUE = 'h43
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int DIV  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    // IDLE spends one cycle noticing the start edge and rx_s arrives two
    // cycles after the pin, so the mid-start sample sits HALF-2 counts
    // into START. The vote decides one cycle later, at mid+1.
`ifdef RX_MAJORITY_VOTE_EN
    localparam int START_TC = HALF - 1;
`else
    localparam int START_TC = HALF - 2;
`endif

    localparam logic [CW-1:0]        START_CNT  = CW'(START_TC);
    localparam logic [CW-1:0]        BIT_CNT    = CW'(DIV - 1);
    localparam logic [3:0]           LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0]           LAST_STOP  = 4'(STOP_BITS - 1);
    localparam logic [DATA_BITS-1:0] RESET_WORD = DATA_BITS'(RESET_VALUE);

    if (DIV < 8) begin : g_div_chk
        $error("uart_rx_param: CLK_FREQ_HZ/BAUD_RATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_par_chk
        $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 samp;
    logic                 par_exp;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 fr_bad;
    logic                 any_one;
    logic                 done;
    logic                 done_fr;
    logic                 done_par;
    logic                 done_zero;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic rx_d1;
    logic rx_d2;

    // Two cycles of rx_s history for the 2-of-3 vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign samp = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
    assign samp = rx_s;
`endif

    // Parity the line should carry for the word now in the shift register.
    always_comb begin
        par_exp = ^shreg;
        if (PARITY_MODE == 2) par_exp = ~(^shreg);
    end

    // Receive FSM: bit timing, deserialisation and per-frame status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            fr_bad    <= 1'b0;
            any_one   <= 1'b0;
            done      <= 1'b0;
            done_fr   <= 1'b0;
            done_par  <= 1'b0;
            done_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                S_START: begin
                    if (cnt == START_CNT) begin
                        cnt <= '0;
                        if (samp) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                            par_bad <= 1'b0;
                            fr_bad  <= 1'b0;
                            any_one <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_CNT) begin
                        cnt     <= '0;
                        shreg   <= {samp, shreg[DATA_BITS-1:1]};
                        any_one <= any_one | samp;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_CNT) begin
                        cnt     <= '0;
                        any_one <= any_one | samp;
                        par_bad <= (samp != par_exp);
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_CNT) begin
                        cnt     <= '0;
                        fr_bad  <= fr_bad | ~samp;
                        any_one <= any_one | samp;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt   <= '0;
                            done      <= 1'b1;
                            done_fr   <= fr_bad | ~samp;
                            done_par  <= par_bad;
                            done_zero <= ~(any_one | samp);
                            state     <= (fr_bad | ~samp) ? S_WAIT_IDLE : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Completion and output handshake: status pulses, word load, consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= RESET_WORD;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            break_det   <= 1'b0;
            if (data_valid && data_ready) data_valid <= 1'b0;
            if (done) begin
                if (done_fr) begin
                    frame_err <= 1'b1;
                    break_det <= done_zero;
                end else if (done_par) begin
                    parity_err <= 1'b1;
                end else if (!data_valid || data_ready) begin
                    data_out   <= shreg;
                    data_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised 8N1-successor UART receiver for the signal logger front end.
- Deserialises frames of configurable data width, parity and stop-bit count from the asynchronous `rx` line.
- Presents each good word on a valid/ready output register, so the downstream logger never misses or double-reads a byte.
- Reports framing, parity, overrun and line-break conditions as single-cycle pulses.

Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency.
- BAUD_RATE, 115_200: line rate. DIV = CLK_FREQ_HZ/BAUD_RATE (integer division). DIV ≥ 8 is required; elaboration error otherwise.
- DATA_BITS, 8: data bits per frame, legal range 5–9.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- RESET_VALUE, 'h43: reset value of data_out, ASCII 'C' ("CLEAR"), zero-extended to DATA_BITS.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- rx, input, 1: serial line; idles high.
- data_out, output, DATA_BITS: last accepted word.
- data_valid, output, 1: data_out holds an unconsumed word.
- data_ready, input, 1: consumer accepts the word when data_valid && data_ready.
- frame_err, output, 1: one-cycle pulse when a stop bit samples 0.
- parity_err, output, 1: one-cycle pulse on parity mismatch.
- overrun_err, output, 1: one-cycle pulse when a word completes while data_valid is still held.
- break_det, output, 1: one-cycle pulse on a break (full frame of zeros, defined below).

Behaviour:
- Reset (async assert, sync release):
  - data_out = RESET_VALUE; all other outputs = 0.
  - Both synchroniser flops = 1; state = IDLE; all counters = 0.
- Input path: `rx` passes through a 2-flop synchroniser giving rx_s. All sampling uses rx_s, so there is 2 cycles of input latency.
- Baud counter: 0..DIV-1, unsigned, width $clog2(DIV)+1. It is reloaded on every state entry and never goes negative.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on rx_s == 0 → START, counter cleared.
  - START: after DIV/2 cycles (mid-start), sample rx_s.
    - If 1: false start → IDLE, no flags raised.
    - If 0: → DATA, bit_cnt = 0.
  - DATA: sample every DIV cycles, LSB first, into the shift register. After DATA_BITS samples → PARITY if PARITY_MODE != 0, else → STOP.
  - PARITY: one sample after DIV cycles.
    - Expected bit = XOR of data bits for even; inverted XOR for odd.
    - A mismatch sets an internal par_bad flag.
  - STOP: STOP_BITS samples, DIV apart. Any 0 sample sets fr_bad. After the last stop sample, the frame completes (see Completion). Then:
    - if fr_bad → WAIT_IDLE;
    - else → IDLE.
  - WAIT_IDLE: stays until rx_s == 1, then → IDLE. No new start bit is recognised while rx_s stays low.
- Completion (cycle after the final stop sample):
  - fr_bad: pulse frame_err; word discarded.
  - fr_bad and all data, parity and stop samples were 0: additionally pulse break_det.
  - par_bad without fr_bad: pulse parity_err; word discarded.
  - Good word, data_valid == 0 (or data_valid && data_ready in this same cycle): load data_out, set data_valid.
  - Good word, data_valid == 1 and data_ready == 0: pulse overrun_err; old word kept; new word dropped.
- Output handshake:
  - data_valid clears on data_valid && data_ready, unless a new word loads in the same cycle.
  - data_out is stable while data_valid is 1.
- Latency: data_valid rises 1 cycle after the last stop-bit sample. From the start-bit falling edge at the pin, that is 2 + DIV/2 + (DATA_BITS + P + STOP_BITS)·DIV + 1 cycles, where P = 1 if PARITY_MODE != 0 and 0 otherwise.
- Back-to-back frames: a start bit arriving immediately after the stop sample is detected in IDLE with no gap required.
- Reset mid-frame: the partial word is discarded; outputs return to reset values immediately.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined:
  - Every start, data, parity and stop sample is the 2-of-3 majority of rx_s at mid-1, mid and mid+1 cycles.
  - The false-start check uses the same vote.
  - The decision is registered at mid+1, so completion shifts 1 cycle later than without the macro.
- Undefined: single sample at mid-bit. No vote logic is synthesised.

Test Plan:
All tests use CLK_FREQ_HZ=1000, BAUD_RATE=100 (DIV=10), 8 data bits, no parity, 1 stop bit, unless stated.
1. Reset, then frame 0x5A with data_ready held 1 → data_out=0x5A. data_valid pulses 1 cycle, 2+5+90+1 = 98 cycles after the start edge. No error flags.
2. data_ready=0, frames 0x11 then 0x22 → data_out stays 0x11. overrun_err pulses once at the end of the second frame. data_ready=1 then clears data_valid.
3. PARITY_MODE=1, frame 0x07 with parity bit 0 (correct parity is 1) → parity_err pulses; data_valid stays 0; data_out keeps its prior value.
4. Frame 0xA5 with stop bit 0, then rx held low 30 cycles, then high → frame_err pulses and the FSM stays in WAIT_IDLE. The next frame 0x3C is received correctly.
5. rx low for 25 bit times → frame_err and break_det pulse once each. No spurious second frame before rx returns high.
6. Low glitch of 3 cycles on rx in IDLE → false start, no outputs change. Asserting rst mid-frame → data_out=0x43, data_valid=0.
